// File: rtl/regs.sv
// regs: RV32I general-purpose register file, 32 x 32-bit, x0 hardwired to zero.
// Latency: read ports 1/2 are combinational with write bypass; the debug port is registered (1 cycle); writes land at the rising edge.
// Backpressure: none; every write is accepted on the edge it is presented.
//
// Ports:
//   clk           core clock, all state updates on the rising edge
//   rst           synchronous active-low reset
//   reg_waddr_i   write index (rd) from execute
//   reg_wdata_i   write data from execute
//   reg_wen_i     write enable from execute
//   reg1_raddr_i  read port 1 index (rs1) from decode
//   reg1_rdata_o  read port 1 data, combinational
//   reg2_raddr_i  read port 2 index (rs2) from decode
//   reg2_rdata_o  read port 2 data, combinational
//   dbg_raddr_i   debug read index
//   dbg_rdata_o   debug read data, registered, committed state only
module regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  reg_waddr_i,
  input  logic [31:0] reg_wdata_i,
  input  logic        reg_wen_i,
  input  logic [4:0]  reg1_raddr_i,
  output logic [31:0] reg1_rdata_o,
  input  logic [4:0]  reg2_raddr_i,
  output logic [31:0] reg2_rdata_o,
  input  logic [4:0]  dbg_raddr_i,
  output logic [31:0] dbg_rdata_o
);

  // x0 has no storage; the array starts at x1.
  logic [31:0] regs_q [1:31];

  logic wr_hit;
  assign wr_hit = reg_wen_i && (reg_waddr_i != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      dbg_rdata_o <= '0;
    end else begin
      if (wr_hit) begin
        regs_q[reg_waddr_i] <= reg_wdata_i;
      end
      // Reads pre-write storage: the debug view never sees the bypass.
      if (dbg_raddr_i == 5'd0) begin
        dbg_rdata_o <= '0;
      end else begin
        dbg_rdata_o <= regs_q[dbg_raddr_i];
      end
    end
  end

  // Read port 1: reset, then x0, then same-cycle bypass from execute, then storage.
  always_comb begin
    reg1_rdata_o = '0;
    if (rst && (reg1_raddr_i != 5'd0)) begin
      if (reg_wen_i && (reg_waddr_i == reg1_raddr_i)) begin
        reg1_rdata_o = reg_wdata_i;
      end else begin
        reg1_rdata_o = regs_q[reg1_raddr_i];
      end
    end
  end

  // Read port 2: same priority as port 1, bypassing independently.
  always_comb begin
    reg2_rdata_o = '0;
    if (rst && (reg2_raddr_i != 5'd0)) begin
      if (reg_wen_i && (reg_waddr_i == reg2_raddr_i)) begin
        reg2_rdata_o = reg_wdata_i;
      end else begin
        reg2_rdata_o = regs_q[reg2_raddr_i];
      end
    end
  end

endmodule
